// File: rtl/if_fetch_buf_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   XLEN_DEF      : default PC width
//   PC_STEP       : byte increment between sequential fetches
//   fetch_entry_t : one buffered instruction together with its PC
package if_pkg;

  localparam int XLEN_DEF = 32;
  localparam int PC_STEP  = 4;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [31:0]         inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_buf_if.sv
// Bus bundle between the fetch buffer, the instruction SRAM and decode.
//   imem_req/imem_we/imem_addr/imem_wdata : SRAM command (driven by master)
//   imem_rdata                            : SRAM read data, one cycle after a read
//   out_valid/out_pc/out_inst             : queue head offered to decode
//   out_ready                             : decode accepts the head
// master = fetch buffer, slave = SRAM + decode side.
interface if_fetch_buf_if
  import if_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int IMEM_AW = 16
);

  logic               imem_req;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_wdata;
  logic [31:0]        imem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_pc;
  logic [31:0]        out_inst;

  modport master (
    output imem_req, imem_we, imem_addr, imem_wdata,
    output out_valid, out_pc, out_inst,
    input  imem_rdata, out_ready
  );

  modport slave (
    input  imem_req, imem_we, imem_addr, imem_wdata,
    input  out_valid, out_pc, out_inst,
    output imem_rdata, out_ready
  );

endinterface

// File: rtl/if_fetch_buf_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} entries.
//   clk, rst : clock, synchronous active-low reset
//   push/din : enqueue din
//   pop      : dequeue head (ignored when empty)
//   flush    : empty the queue; overrides push and pop
//   count    : occupancy 0..DEPTH
//   head     : oldest entry
// DEPTH must be a power of two so the pointers wrap naturally.
module if_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/if_fetch_buf.sv
// Instruction-fetch front end: owns the fetch PC, issues word reads to a
// 1-cycle synchronous SRAM, and queues returned {pc, inst} for decode.
//   clk, rst       : clock, synchronous active-low reset
//   redirect       : branch/jump taken (flushes queue, kills in-flight read)
//   redirect_addr  : new fetch PC, low two bits ignored
//   dbg_en/dbg_we/dbg_addr/dbg_wdata : debug access to the SRAM, halts fetch
//   bus            : SRAM command/response and decode handshake
module if_fetch_buf
  import if_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              DEPTH    = 4,
  parameter int              IMEM_AW  = 16,
  parameter logic [XLEN-1:0] RST_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_addr,
  input  logic               dbg_en,
  input  logic               dbg_we,
  input  logic [IMEM_AW-1:0] dbg_addr,
  input  logic [31:0]        dbg_wdata,
  if_fetch_buf_if.master     bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic            issue;
  logic            push;
  logic            flush;
  logic [CW-1:0]   count;
  logic [XLEN+31:0] head;

  // Credit check counts the in-flight read so the queue can never overflow.
  assign issue = rst && !dbg_en && !redirect &&
                 ((count + CW'(inflight)) < CW'(DEPTH));
  // A redirect or debug takeover kills the response arriving this cycle.
  assign push  = rst && inflight && !redirect && !dbg_en;
  assign flush = redirect || dbg_en;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= RST_ADDR;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      if (redirect)   fetch_pc <= redirect_addr & ~XLEN'(3);
      else if (issue) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
      inflight <= issue;
      if (issue) inflight_pc <= fetch_pc;
    end
  end

  always_comb begin
    bus.imem_req   = 1'b0;
    bus.imem_we    = 1'b0;
    bus.imem_addr  = '0;
    bus.imem_wdata = '0;
    if (rst && dbg_en) begin
      bus.imem_req   = 1'b1;
      bus.imem_we    = dbg_we;
      bus.imem_addr  = dbg_addr;
      bus.imem_wdata = dbg_wdata;
    end else if (issue) begin
      bus.imem_req   = 1'b1;
      bus.imem_addr  = fetch_pc[IMEM_AW+1:2];
    end
  end

  if_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN + 32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (bus.out_valid && bus.out_ready),
    .flush (flush),
    .din   ({inflight_pc, bus.imem_rdata}),
    .count (count),
    .head  (head)
  );

  assign bus.out_valid = (count != '0);
  assign {bus.out_pc, bus.out_inst} = head;

endmodule

// File: tb/tb_if_fetch_buf.sv
module tb_if_fetch_buf;
  import if_pkg::*;

  localparam int          DEPTH    = 4;
  localparam int          IMEM_AW  = 16;
  localparam logic [31:0] RST_ADDR = 32'h100;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        dbg_en;
  logic        dbg_we;
  logic [15:0] dbg_addr;
  logic [31:0] dbg_wdata;

  if_fetch_buf_if #(.XLEN(32), .IMEM_AW(IMEM_AW)) bus ();

  if_fetch_buf #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .IMEM_AW  (IMEM_AW),
    .RST_ADDR (RST_ADDR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .dbg_en        (dbg_en),
    .dbg_we        (dbg_we),
    .dbg_addr      (dbg_addr),
    .dbg_wdata     (dbg_wdata),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SRAM model and the bench's own reference copy of its contents
  logic [31:0] sram    [65536];
  logic [31:0] ref_mem [65536];

  always @(posedge clk) begin
    if (bus.imem_req) begin
      if (bus.imem_we) sram[bus.imem_addr] <= bus.imem_wdata;
      else             bus.imem_rdata      <= sram[bus.imem_addr];
    end
  end

  // Behavioural model: queue of expected entries plus one pending read
  fetch_entry_t mq[$];
  logic [31:0]  m_pc;
  logic [31:0]  m_ppc;
  bit           m_pend;
  bit           started;

  function automatic bit m_issue();
    return rst && !dbg_en && !redirect && ((mq.size() + int'(m_pend)) < DEPTH);
  endfunction

  always @(posedge clk) begin : model
    bit iss;
    fetch_entry_t e;
    if (!rst) begin
      m_pc    = RST_ADDR;
      m_pend  = 1'b0;
      mq.delete();
      started = 1'b1;
    end else begin
      iss = m_issue();
      if (redirect || dbg_en) begin
        mq.delete();
      end else begin
        if (mq.size() != 0 && bus.out_ready) void'(mq.pop_front());
        if (m_pend) begin
          e.pc   = m_ppc;
          e.inst = ref_mem[m_ppc[17:2]];
          mq.push_back(e);
        end
      end
      m_pend = iss;
      if (iss) m_ppc = m_pc;
      if (redirect)  m_pc = redirect_addr & ~32'd3;
      else if (iss)  m_pc = m_pc + 32'd4;
    end
  end

  always @(negedge clk) begin : compare
    bit exp_req;
    if (started) begin
      exp_req = rst && (dbg_en || m_issue());
      chk("out_valid", bus.out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("out_pc", bus.out_pc, mq[0].pc);
        chk("out_inst", bus.out_inst, mq[0].inst);
      end
      chk("imem_req", bus.imem_req, exp_req);
      chk("imem_we", bus.imem_we, rst && dbg_en && dbg_we);
      chk("imem_wdata", bus.imem_wdata, (rst && dbg_en) ? dbg_wdata : 32'h0);
      if (!rst)          chk("imem_addr_rst", bus.imem_addr, 16'h0);
      else if (dbg_en)   chk("imem_addr_dbg", bus.imem_addr, dbg_addr);
      else if (exp_req)  chk("imem_addr", bus.imem_addr, m_pc[17:2]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int reqs;

  initial begin
    for (int unsigned i = 0; i < 65536; i++) begin
      sram[i]    = 32'h5A000000 | i;
      ref_mem[i] = 32'h5A000000 | i;
    end
    for (int unsigned i = 0; i < 4; i++) begin
      sram[16'h40 + i]    = 32'hA0 + i;
      ref_mem[16'h40 + i] = 32'hA0 + i;
    end
    rst = 1'b0; redirect = 1'b0; redirect_addr = '0;
    dbg_en = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    bus.out_ready = 1'b0;

    // reset state
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_req", bus.imem_req, 0);
    chk("rst_addr", bus.imem_addr, 0);

    // cold start and stream
    cyc(); rst = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    chk("cold_req", bus.imem_req, 1);
    chk("cold_addr", bus.imem_addr, 16'h40);
    @(negedge clk);
    chk("cold_c1_valid", bus.out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stream_valid", bus.out_valid, 1);
      chk("stream_pc", bus.out_pc, 32'h100 + 32'(4 * k));
      chk("stream_inst", bus.out_inst, 32'hA0 + 32'(k));
    end

    // backpressure from an empty queue
    cyc(); redirect = 1'b1; redirect_addr = 32'h300; bus.out_ready = 1'b0;
    cyc(); redirect = 1'b0;
    reqs = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.imem_req) reqs++;
    end
    chk("bp_reqs", reqs, DEPTH);
    chk("bp_head", bus.out_pc, 32'h300);
    cyc(); bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("drain_valid", bus.out_valid, 1);
      chk("drain_pc", bus.out_pc, 32'h300 + 32'(4 * k));
    end

    // redirect with a read in flight
    cyc(); redirect = 1'b1; redirect_addr = 32'h203;
    cyc(); redirect = 1'b0;
    @(negedge clk);
    chk("redir_t1_valid", bus.out_valid, 0);
    chk("redir_t1_req", bus.imem_req, 1);
    chk("redir_t1_addr", bus.imem_addr, 16'h80);
    @(negedge clk);
    chk("redir_t2_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("redir_t3_valid", bus.out_valid, 1);
    chk("redir_t3_pc", bus.out_pc, 32'h200);
    @(negedge clk);
    chk("redir_t4_pc", bus.out_pc, 32'h204);

    // redirect together with a pop while count is 3
    cyc(); redirect = 1'b1; redirect_addr = 32'h500; bus.out_ready = 1'b0;
    cyc(); redirect = 1'b0;
    repeat (4) cyc();
    redirect = 1'b1; redirect_addr = 32'h600; bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rp_head_valid", bus.out_valid, 1);
    chk("rp_head_pc", bus.out_pc, 32'h500);
    cyc(); redirect = 1'b0;
    @(negedge clk);
    chk("rp_t1_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("rp_t2_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("rp_t3_pc", bus.out_pc, 32'h600);

    // debug load then redirect to the loaded word
    cyc(); dbg_en = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h10; dbg_wdata = 32'hDEADBEEF;
    ref_mem[16'h10] = 32'hDEADBEEF;
    @(negedge clk);
    chk("dbg_req", bus.imem_req, 1);
    chk("dbg_we", bus.imem_we, 1);
    chk("dbg_addr", bus.imem_addr, 16'h10);
    chk("dbg_wdata", bus.imem_wdata, 32'hDEADBEEF);
    cyc(); dbg_we = 1'b0;
    @(negedge clk);
    chk("dbg_flushed", bus.out_valid, 0);
    cyc(); dbg_en = 1'b0; redirect = 1'b1; redirect_addr = 32'h40;
    @(negedge clk);
    chk("dbg_redir_req", bus.imem_req, 0);
    cyc(); redirect = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("dbg_load_valid", bus.out_valid, 1);
    chk("dbg_load_pc", bus.out_pc, 32'h40);
    chk("dbg_load_inst", bus.out_inst, 32'hDEADBEEF);

    // reset mid-stream with two entries queued
    repeat (3) cyc();
    bus.out_ready = 1'b0;
    cyc(); rst = 1'b0; bus.out_ready = 1'b1;
    cyc(); rst = 1'b1;
    @(negedge clk);
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_addr", bus.imem_addr, 16'h40);
    @(negedge clk);
    @(negedge clk);
    chk("mrst_pc", bus.out_pc, 32'h100);
    chk("mrst_inst", bus.out_inst, 32'hA0);

    repeat (5) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_buf.md
# if_fetch_buf

Parametrised instruction-fetch front end: holds the fetch PC, issues word requests to a synchronous single-port instruction SRAM, and buffers returned instructions with their PCs in a DEPTH-entry queue. The queue hands instructions to decode with a valid/ready handshake. Branch and jump redirects flush the queue and kill in-flight reads. A debug port shares the SRAM for program loading, which keeps the debug-load path available without reset. It sits between the PC/branch logic and the decode stage.

## Interface
- XLEN, 32: PC width; pc increments by 4.
- DEPTH, 4: queue entries; power of two, ≥2.
- IMEM_AW, 16: SRAM word-address width; SRAM is indexed by pc[IMEM_AW+1:2].
- RST_ADDR, 0: fetch PC after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- redirect  in  1  branch/jump taken; one-cycle pulse.
- redirect_addr  in  XLEN  new fetch PC; bits [1:0] ignored (treated as 0).
- dbg_en  in  1  debug owns the SRAM; fetch halted.
- dbg_we  in  1  debug write strobe.
- dbg_addr  in  IMEM_AW  debug word address.
- dbg_wdata  in  32  debug write data.
- imem_req  out  1  SRAM access this cycle.
- imem_we  out  1  SRAM write (debug only).
- imem_addr  out  IMEM_AW  SRAM word address.
- imem_wdata  out  32  SRAM write data.
- imem_rdata  in  32  read data; valid the cycle after a read request.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts head.
- out_pc  out  XLEN  PC of head.
- out_inst  out  32  instruction at head.

## Operation
- State:
  - fetch_pc
  - queue (pc, inst)
  - one in-flight bit (inflight) and its pc (inflight_pc)
- **Fetch issue.** A read is issued when all of the following hold: rst high, dbg_en low, redirect low, count + inflight < DEPTH.
  - Outputs: imem_req=1, imem_we=0, imem_addr=fetch_pc[IMEM_AW+1:2].
  - Updates: fetch_pc += 4 (wraps modulo 2^XLEN); inflight<=1; inflight_pc<=fetch_pc.
- **Response.** If inflight is set and not killed, {inflight_pc, imem_rdata} is pushed into the queue. The credit check guarantees the queue never overflows.
- **Pop.** When out_valid && out_ready, the head is removed. Push and pop in the same cycle leave count unchanged.
- **Redirect** (highest priority after reset):
  - queue flushed (count<=0);
  - current-cycle response discarded;
  - inflight<=0;
  - fetch_pc<=redirect_addr & ~3;
  - no request issued that cycle.
  - A simultaneous pop is void.
- **Debug.** While dbg_en=1:
  - SRAM port is driven from dbg_*: imem_req=1, imem_we=dbg_we, imem_addr=dbg_addr, imem_wdata=dbg_wdata.
  - Queue is flushed and in-flight data discarded, both on the first dbg_en cycle.
  - fetch_pc holds unless redirect is asserted; redirect still loads fetch_pc.
  - When dbg_en falls, fetch resumes from fetch_pc in the next cycle.
- imem_wdata=0 and imem_we=0 outside debug.
- out_valid = (count != 0); out_pc and out_inst are taken from the head entry.

## Timing
- Reset (rst=0 at an edge), all of which take effect that edge:
  - fetch_pc=RST_ADDR, count=0, inflight=0;
  - out_valid=0, imem_req=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - Reset in mid-operation discards everything.
- Cold start, counting from the first cycle with rst=1 (cycle 0):
  - cycle 0: request for RST_ADDR;
  - cycle 1: data returned;
  - cycle 2: out_valid=1 with out_pc=RST_ADDR.
  - Latency is 2 cycles from request to head visibility when the queue was empty.
- Redirect at cycle t:
  - t+1: out_valid=0 and request for the target;
  - t+3: out_valid=1 with out_pc=target.
- Redirect one cycle after a request: the returning data is dropped, and the stale pc never appears on out_pc.
- Steady state with out_ready=1 gives 1 instruction per cycle.
- With out_ready=0, requests stop once count+inflight=DEPTH and resume the cycle after the first pop.
- The SRAM is modelled as 1-cycle synchronous read; debug writes take effect at the edge where imem_we=1.

## Structure
- Package if_pkg:
  - XLEN default;
  - PC_STEP=4;
  - fetch-entry struct {pc, inst}.
- Sub-module if_fifo: synchronous FIFO (parameters DEPTH and WIDTH=XLEN+32) with push, pop, flush, count, head.
  - Simultaneous push and pop is legal.
  - flush overrides push.
- Top level contains fetch_pc, credit/inflight logic, redirect/kill, and the debug port mux.

## Test plan
- **Reset and stream:** RST_ADDR=0x100, SRAM words 0x40..0x43 = 0xA0..0xA3, out_ready=1 -> out_pc 0x100,0x104,0x108,0x10C on consecutive cycles, starting 2 cycles after reset release.
- **Backpressure:** out_ready=0 for 10 cycles -> exactly DEPTH=4 requests issued, count=4. Then out_ready=1 -> entries drain in order with no gaps or duplicates.
- **Redirect:** redirect to 0x203 while an entry is in flight -> out_pc sequence continues at 0x200 with out_valid high at t+3, and the in-flight PC never appears.
- **Redirect plus pop:** redirect and out_ready in the same cycle with count=3 -> queue becomes empty, and no entry beyond the head is consumed.
- **Debug load:** dbg_en=1, write 0xDEADBEEF to address 0x10, dbg_en=0, redirect to 0x40 -> out_inst=0xDEADBEEF with out_pc=0x40.
- **Reset mid-stream:** rst=0 for one cycle with count=2 -> out_valid=0 next cycle, and fetch restarts at RST_ADDR.
